data_mem_bank: RTL
==================

Name: data_mem_bank

Overview:
Parametrised successor to the single-cycle data RAM. It is a byte-addressed, little-endian data memory with byte, halfword and word accesses. Loads return sign- or zero-extended data, and misaligned accesses are reported as errors. Accesses use a valid/ready request handshake and a fixed, configurable number of wait states. It sits on the load/store path of the MIPS-like core and its multi-cycle successors.

Parameters:
ADDR_W, 8, byte-address width; depth = 2^(ADDR_W-2) words of 32 bits
WAIT_CYCLES, 1, extra wait-state cycles per access (0..15)
INIT_STEP, 4, power-up contents: word[i] = INIT_STEP*i (initial only, not reset)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  load extension: 1 sign-extend, 0 zero-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data; right-justified for byte and half
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  misaligned or illegal-size access, valid with rsp_valid

Behaviour:
- Reset:
  - Applied when rst_n=0 at a rising edge.
  - State=IDLE, wait counter=0, req_ready=0 during the reset cycle.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE with rst_n=1.
  - A request is accepted when req_valid & req_ready at a rising edge; all req_* fields are latched at that edge.
- Error check at accept:
  - Error conditions: size=11; half with addr[0]=1; word with addr[1:0]!=0.
  - On error: next state is RESP directly, no memory access, rsp_err=1, rsp_rdata=0.
- Normal accept:
  - WAIT_CYCLES>0: go to WAIT, counter loads WAIT_CYCLES-1. Decrement each cycle; on counter=0, go to RESP.
  - WAIT_CYCLES=0: go straight to RESP.
- Commit point: on the edge entering RESP.
  - Stores write only the selected byte lanes.
  - Loads sample the addressed word.
- Lane selection:
  - Word index = addr[ADDR_W-1:2].
  - Byte lane = addr[1:0] (lane 0 = bits 7:0).
  - Half lane = addr[1] (0 = bits 15:0).
- Load extraction: the selected byte or half is right-justified, then extended per req_signed. Word loads ignore req_signed.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_rdata and rsp_err held stable.
  - Next state is IDLE unconditionally; there is no response backpressure.
  - Outputs return to 0 when leaving RESP.
- Timing: a request accepted at edge T0 gives rsp_valid=1 in the cycle after edge T0+WAIT_CYCLES. Error responses arrive in the cycle after T0.
- Throughput: at most one request per WAIT_CYCLES+2 cycles (error: 2 cycles).
- req_valid while req_ready=0 is ignored; the requester must hold it.
- Reset mid-operation:
  - In WAIT, the pending store is dropped and memory is unchanged.
  - Reset coinciding with the commit edge takes priority: no write.
- Stores to the same word as the next load are visible to that load (commit precedes the next accept).

Test Plan:
- Reset, then word load addr 0x14, WAIT_CYCLES=1 -> req_ready drops; rsp_valid two cycles after the accept edge; rsp_rdata=0x00000014, rsp_err=0.
- Byte store 0x80 at 0x09, then signed byte load 0x09 -> 0xFFFFFF80. Unsigned byte load 0x09 -> 0x00000080. Word load 0x08 -> 0x00008008.
- Half store 0xBEEF at 0x0E, then signed half load 0x0E -> 0xFFFFBEEF. Word load 0x0C -> 0xBEEF000C.
- Word load 0x06, half load 0x03, and size=11 at 0x00 -> each rsp_err=1, rsp_rdata=0 one cycle after accept. A following word load 0x04 still returns 0x00000004.
- Word store 0xDEADBEEF at 0x10 with rst_n pulsed low during WAIT -> outputs zero, state IDLE, and a subsequent load 0x10 returns 0x00000010.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds, back-to-back requests with req_valid held high -> accepts spaced 2 and 5 cycles apart. Exactly one rsp_valid pulse per request, with correct data for each.

Source files
------------

// File: rtl/data_mem_bank.sv
// rtl/data_mem_bank.sv - byte-addressed little-endian data memory with wait states and misalignment errors
//
// Byte/half/word loads and stores over a 32-bit word array. One request is in
// flight at a time: accept in IDLE, optional WAIT_CYCLES wait states, then a
// single-cycle response. The memory write / load sample happens on the edge
// that enters RESP.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst_n       synchronous active-low reset (memory contents are kept)
//   req_valid   request present
//   req_ready   request accepted this cycle if req_valid (IDLE and not in reset)
//   req_we      1 = store, 0 = load
//   req_size    00 byte, 01 half, 10 word, 11 illegal
//   req_signed  load extension: 1 sign, 0 zero
//   req_addr    byte address
//   req_wdata   store data, right-justified for byte/half
//   rsp_valid   one-cycle response pulse
//   rsp_rdata   load result, 0 for stores and errors
//   rsp_err     misaligned or illegal size, qualified by rsp_valid

module data_mem_bank #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int INIT_STEP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam int IDX_W = ADDR_W - 2;
    // Counter preload for the WAIT phase; unused when there are no wait states.
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Power-up image: word[i] = INIT_STEP*i. Reset deliberately leaves it alone.
    function automatic logic [DEPTH*32-1:0] init_image();
        logic [DEPTH*32-1:0] img;
        img = '0;
        for (int i = 0; i < DEPTH; i++) begin
            img[i*32 +: 32] = 32'(INIT_STEP * i);
        end
        return img;
    endfunction

    logic [DEPTH-1:0][31:0] mem_q = init_image();

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                accept;
    logic                enter_resp;
    logic                misalign;
    logic                commit_wr;

    // Access fields in effect this cycle: straight from the request port in
    // IDLE (so a zero-wait access can commit on its accept edge), otherwise
    // the copy latched at accept.
    logic                cur_we;
    logic [1:0]          cur_size;
    logic                cur_signed;
    logic [ADDR_W-1:0]   cur_addr;
    logic [31:0]         cur_wdata;

    logic [IDX_W-1:0]    word_idx;
    logic [31:0]         rd_word;
    logic [31:0]         rd_shift;
    logic [31:0]         ld_data;
    logic [3:0]          wmask;
    logic [31:0]         wlanes;

    assign req_ready = (state_q == ST_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    always_comb begin
        cur_we     = we_q;
        cur_size   = size_q;
        cur_signed = signed_q;
        cur_addr   = addr_q;
        cur_wdata  = wdata_q;
        if (state_q == ST_IDLE) begin
            cur_we     = req_we;
            cur_size   = req_size;
            cur_signed = req_signed;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
        end
    end

    always_comb begin
        misalign = 1'b0;
        case (cur_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = cur_addr[0];
            2'b10:   misalign = (cur_addr[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (misalign) begin
                        state_d = ST_RESP;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    // Erroring requests never reach WAIT, so misalign only gates the IDLE path.
    assign commit_wr  = enter_resp && !misalign && cur_we;

    // Load path: bring the addressed byte/half down to bit 0, then extend.
    // A legal half always has addr[0]=0, so the byte-granular shift serves both.
    assign word_idx = cur_addr[ADDR_W-1:2];
    assign rd_word  = mem_q[word_idx];
    assign rd_shift = rd_word >> {cur_addr[1:0], 3'b000};

    always_comb begin
        ld_data = rd_word;
        case (cur_size)
            2'b00:   ld_data = {{24{cur_signed & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   ld_data = {{16{cur_signed & rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase
    end

    // Store path: replicate the right-justified data across lanes and let the
    // mask pick the addressed ones.
    always_comb begin
        wmask  = 4'b1111;
        wlanes = cur_wdata;
        case (cur_size)
            2'b00: begin
                wmask  = 4'b0001 << cur_addr[1:0];
                wlanes = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                wmask  = cur_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{cur_wdata[15:0]}};
            end
            default: begin
                wmask  = 4'b1111;
                wlanes = cur_wdata;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = misalign;
            rdata_d = (misalign || cur_we) ? 32'd0 : ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

    // Array write; a reset on the commit edge suppresses the store.
    always_ff @(posedge clk) begin
        if (rst_n && commit_wr) begin
            for (int l = 0; l < 4; l++) begin
                if (wmask[l]) begin
                    mem_q[word_idx][8*l +: 8] <= wlanes[8*l +: 8];
                end
            end
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid && err_q;

endmodule
